// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed hex display scanner for a shared
// seven-segment bus. Each frame is shown from one snapshot of the inputs.
// The snapshot is taken each time the scan wraps back to digit 0.
// Optional feature macro: SEG7_SCAN_LEADING_ZERO_BLANK_EN (blanks leading zero digits).
module seg7_scan_ctrl #(
  parameter int unsigned clk_mhz  = 50,
  parameter int unsigned digit_hz = 1000,
  parameter int unsigned w_digit  = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*w_digit-1:0]   value,
  input  logic [w_digit-1:0]     dots,
  input  logic [w_digit-1:0]     digit_en,
  output logic [7:0]             abcdefgh,
  output logic [w_digit-1:0]     digit,
  output logic                   frame_start
);

  localparam int unsigned PERIOD = clk_mhz * 1_000_000 / digit_hz;
  localparam int unsigned CNT_W  = $clog2(PERIOD);
  localparam int unsigned IDX_W  = $clog2(w_digit);

  // Reject slot lengths too short for the tick counter.
  if (PERIOD < 2) begin : g_period_chk
    $error("seg7_scan_ctrl: slot length PERIOD must be at least 2 cycles");
  end

  // Hex nibble to abcdefg segment pattern.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1111110;
      4'h1: seg7 = 7'b0110000;
      4'h2: seg7 = 7'b1101101;
      4'h3: seg7 = 7'b1111001;
      4'h4: seg7 = 7'b0110011;
      4'h5: seg7 = 7'b1011011;
      4'h6: seg7 = 7'b1011111;
      4'h7: seg7 = 7'b1110000;
      4'h8: seg7 = 7'b1111111;
      4'h9: seg7 = 7'b1111011;
      4'hA: seg7 = 7'b1110111;
      4'hB: seg7 = 7'b0011111;
      4'hC: seg7 = 7'b1001110;
      4'hD: seg7 = 7'b0111101;
      4'hE: seg7 = 7'b1001111;
      default: seg7 = 7'b1000111;
    endcase
  endfunction

  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [4*w_digit-1:0] value_s;
  logic [w_digit-1:0]   dots_s;
  logic [w_digit-1:0]   en_s;

  logic                 advance;
  logic                 wrap;
  logic [IDX_W-1:0]     idx_next;
  logic [4*w_digit-1:0] value_n;
  logic [w_digit-1:0]   dots_n;
  logic [w_digit-1:0]   en_n;
  logic [w_digit-1:0]   lz_blank;
  logic [w_digit-1:0]   digit_next;
  logic [3:0]           nib;
  logic                 dot_sel;
  logic                 en_sel;
  logic                 blank_sel;
  logic [7:0]           pattern;

  // Slot timing and the snapshot that will be in force for the next slot.
  always_comb begin
    advance  = (cnt == CNT_W'(PERIOD - 1));
    wrap     = advance && (idx == IDX_W'(w_digit - 1));
    idx_next = wrap ? '0 : idx + IDX_W'(1);
    value_n  = wrap ? value    : value_s;
    dots_n   = wrap ? dots     : dots_s;
    en_n     = wrap ? digit_en : en_s;
  end

  // Leading-zero blank mask, derived from the snapshot so it is frame-stable.
`ifdef SEG7_SCAN_LEADING_ZERO_BLANK_EN
  always_comb begin
    logic upper_zero;
    lz_blank   = '0;
    upper_zero = 1'b1;
    for (int i = w_digit - 1; i >= 1; i--) begin
      upper_zero  = upper_zero && (value_n[4*i +: 4] == 4'h0);
      lz_blank[i] = upper_zero;
    end
  end
`else
  always_comb begin
    lz_blank = '0;
  end
`endif

  // Pattern and strobe for the position about to be driven.
  always_comb begin
    nib       = 4'h0;
    dot_sel   = 1'b0;
    en_sel    = 1'b0;
    blank_sel = 1'b0;
    for (int i = 0; i < w_digit; i++) begin
      if (IDX_W'(i) == idx_next) begin
        nib       = value_n[4*i +: 4];
        dot_sel   = dots_n[i];
        en_sel    = en_n[i];
        blank_sel = lz_blank[i];
      end
    end
    if (!en_sel)
      pattern = 8'h00;
    else if (blank_sel)
      pattern = {7'b0, dot_sel};
    else
      pattern = {seg7(nib), dot_sel};
    digit_next = {{(w_digit-1){1'b0}}, 1'b1} << idx_next;
  end

  // Scan state, snapshot and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      value_s     <= '0;
      dots_s      <= '0;
      en_s        <= '1;
      digit       <= {{(w_digit-1){1'b0}}, 1'b1};
      abcdefgh    <= 8'b11111100;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      cnt         <= advance ? '0 : cnt + CNT_W'(1);
      if (advance) begin
        idx         <= idx_next;
        digit       <= digit_next;
        abcdefgh    <= pattern;
        frame_start <= wrap;
        if (wrap) begin
          value_s <= value;
          dots_s  <= dots;
          en_s    <= digit_en;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed testbench for seg7_scan_ctrl with PERIOD = 4 and six digits.
// Also honours SEG7_SCAN_LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] value;
  logic [5:0]  dots;
  logic [5:0]  digit_en;
  logic [7:0]  abcdefgh;
  logic [5:0]  digit;
  logic        frame_start;

  int n_checks = 0;
  int n_pass   = 0;

  seg7_scan_ctrl #(.clk_mhz(1), .digit_hz(250000), .w_digit(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .dots        (dots),
    .digit_en    (digit_en),
    .abcdefgh    (abcdefgh),
    .digit       (digit),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Checks one slot for all four of its cycles; leaves time at the next slot start.
  task automatic check_slot(input string tag, input logic [5:0] d, input logic [7:0] s,
                            input logic fs);
    check({tag, "_fs"}, 32'(frame_start), 32'(fs));
    for (int k = 0; k < 4; k++) begin
      check({tag, "_digit"}, 32'(digit), 32'(d));
      check({tag, "_seg"}, 32'(abcdefgh), 32'(s));
      step(1);
    end
  endtask

  // segs byte i is the expected pattern of digit i.
  task automatic check_frame(input string tag, input logic [47:0] segs, input logic fs);
    for (int i = 0; i < 6; i++) begin
      logic [5:0] d;
      d = 6'd1 << i;
      check_slot($sformatf("%s_s%0d", tag, i), d, segs[8*i +: 8], (i == 0) ? fs : 1'b0);
    end
  endtask

  // Continuous structural checks: one-hot strobe, slot length, frame period.
  logic [5:0] prev_digit = 6'd1;
  int         run_len    = 0;
  int         fs_gap     = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_digit <= 6'd1;
      run_len    <= 0;
      fs_gap     <= 0;
    end else begin
      check("onehot", 32'($onehot(digit)), 32'd1);
      if (digit != prev_digit) begin
        check("slot_len", 32'(run_len), 32'd4);
        run_len    <= 1;
        prev_digit <= digit;
      end else begin
        run_len <= run_len + 1;
      end
      if (frame_start) begin
        check("frame_len", 32'(fs_gap), 32'd24);
        fs_gap <= 1;
      end else begin
        fs_gap <= fs_gap + 1;
      end
    end
  end

  initial begin
    value    = 24'h123456;
    dots     = 6'b000000;
    digit_en = 6'h3F;
    rst      = 1'b1;

    step(1);
    check("rst_digit", 32'(digit), 32'h01);
    check("rst_seg", 32'(abcdefgh), 32'hFC);
    check("rst_fs", 32'(frame_start), 32'd0);
    step(1);
    rst = 1'b0;

    // First frame shows the reset snapshot; second shows 123456.
    check_frame("f0", {6{8'hFC}}, 1'b0);
    check_frame("f1", {8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE}, 1'b1);

    // Mid-frame input change must not tear the frame.
    value = 24'h000000;
    step(24);
    check_slot("f3_s0", 6'd1, 8'hFC, 1'b1);
    check_slot("f3_s1", 6'd2, 8'hFC, 1'b0);
    value = 24'hFFFFFF;
    check_slot("f3_s2", 6'd4,  8'hFC, 1'b0);
    check_slot("f3_s3", 6'd8,  8'hFC, 1'b0);
    check_slot("f3_s4", 6'd16, 8'hFC, 1'b0);
    check_slot("f3_s5", 6'd32, 8'hFC, 1'b0);

    // Disabled digit blanks fully; dp follows dots on enabled digits.
    value    = 24'h888888;
    dots     = 6'b000100;
    digit_en = 6'b111011;
    check_frame("f4", {6{8'h8E}}, 1'b1);
    dots     = 6'b100001;
    digit_en = 6'h3F;
    check_frame("f5", {8'hFE, 8'hFE, 8'hFE, 8'h00, 8'hFE, 8'hFE}, 1'b1);
    value = 24'h000050;
    dots  = 6'b000000;
    check_frame("f6", {8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFF}, 1'b1);
    value = 24'h000000;
    dots  = 6'b100000;
`ifdef SEG7_SCAN_LEADING_ZERO_BLANK_EN
    check_frame("f7", {8'h00, 8'h00, 8'h00, 8'h00, 8'hB6, 8'hFC}, 1'b1);
    value = 24'h0A0300;
    dots  = 6'b000000;
    check_frame("f8", {8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFC}, 1'b1);
    check_frame("f9", {8'h00, 8'hEE, 8'hFC, 8'hF2, 8'hFC, 8'hFC}, 1'b1);
`else
    check_frame("f7", {8'hFC, 8'hFC, 8'hFC, 8'hFC, 8'hB6, 8'hFC}, 1'b1);
    value = 24'h0A0300;
    dots  = 6'b000000;
    check_frame("f8", {8'hFD, 8'hFC, 8'hFC, 8'hFC, 8'hFC, 8'hFC}, 1'b1);
    check_frame("f9", {8'hFC, 8'hEE, 8'hFC, 8'hF2, 8'hFC, 8'hFC}, 1'b1);
`endif

    // One-cycle reset in the middle of slot 4.
    step(17);
    check("pre_rst_digit", 32'(digit), 32'h10);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mid_rst_digit", 32'(digit), 32'h01);
    check("mid_rst_seg", 32'(abcdefgh), 32'hFC);
    check("mid_rst_fs", 32'(frame_start), 32'd0);
    check_slot("r_s0", 6'd1, 8'hFC, 1'b0);
    check("r_s1_digit", 32'(digit), 32'h02);
    check("r_s1_seg", 32'(abcdefgh), 32'hFC);

    // Long free run under the continuous checks.
    step(1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
